// File: rtl/dpll_frame_rx_pkg.sv
// Shared definitions for the DPLL frame receiver: FSM state codes, parity modes
// and a constant-width helper.
package dpll_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAR  = 3'd2,
        ST_STOP = 3'd3,
        ST_BRK  = 3'd4
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dpll_frame_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received words with their
// error flags. Pointers carry one extra wrap bit to tell full from empty.
module frame_fifo
    import dpll_frame_rx_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // A pop frees the head slot in the same clk, so a full FIFO may accept a push then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wptr_d = wptr_q + (AW + 1)'(do_push);
    assign rptr_d = rptr_q + (AW + 1)'(do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/dpll_frame_rx.sv
// Async serial frame deserializer behind the DPLL bit-recovery stage: frames
// start/data/parity/stop bits on lock-qualified strobes and queues checked words.
module dpll_frame_rx
    import dpll_frame_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 stb_i,
    input  logic                 dat_i,
    input  logic                 lock_i,
    input  logic                 rd_i,
    output logic                 rdy_o,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 perr_o,
    output logic                 ferr_o,
    output logic                 ovr_o,
    output logic                 busy_o
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("dpll_frame_rx: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("dpll_frame_rx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("dpll_frame_rx: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dpll_frame_rx: FIFO_DEPTH must be a power of 2, >= 2");
    end

    localparam int          FW        = DATA_BITS + 2;
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic        PAR_EXP   = (PARITY == PAR_ODD);

    rx_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   pacc_q, pacc_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   push_q, push_d;
    logic [FW-1:0]          word_q, word_d;
    logic                   ovr_q, ovr_d;
    logic                   ferr_new;
    logic                   samp;

    logic [FW-1:0]          fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign samp = stb_i & lock_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        pacc_d   = pacc_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        push_d   = 1'b0;
        word_d   = word_q;
        ferr_new = ferr_q | ~dat_i;
        unique case (state_q)
            ST_IDLE: begin
                if (samp && !dat_i) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    pacc_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_DATA: begin
                if (!lock_i) begin
                    state_d = ST_IDLE;
                end else if (stb_i) begin
                    sh_d   = {dat_i, sh_q[DATA_BITS-1:1]};
                    pacc_d = pacc_q ^ dat_i;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (!lock_i) begin
                    state_d = ST_IDLE;
                end else if (stb_i) begin
                    perr_d  = ((pacc_q ^ dat_i) != PAR_EXP);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!lock_i) begin
                    state_d = ST_IDLE;
                end else if (stb_i) begin
                    ferr_d = ferr_new;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == LAST_STOP) begin
                        push_d  = 1'b1;
                        word_d  = {ferr_new, perr_q, sh_q};
                        cnt_d   = '0;
                        // A bad stop usually means a break; hold off re-framing until the line idles high.
                        state_d = ferr_new ? ST_BRK : ST_IDLE;
                    end
                end
            end
            ST_BRK: begin
                if (!lock_i || (stb_i && dat_i)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ovr_d = ovr_q | (push_q & fifo_full & ~(rd_i & ~fifo_empty));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            pacc_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            pacc_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            pacc_q  <= pacc_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            push_q  <= push_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
        end
    end

    frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .push_i  (push_q),
        .din_i   (word_q),
        .pop_i   (rd_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rdy_o                    = ~fifo_empty;
    assign {ferr_o, perr_o, dat_o}  = fifo_empty ? '0 : fifo_dout;
    assign ovr_o                    = ovr_q;
    assign busy_o                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dpll_frame_rx.sv
// Directed bench for dpll_frame_rx: one 8N1 and one 8O1 instance share the line;
// each step drives frames and checks the head word, flags and timing.
module tb_dpll_frame_rx;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       stb;
    logic       dat;
    logic       lock;
    logic       rd;

    logic       rdy_n, perr_n, ferr_n, ovr_n, busy_n;
    logic [7:0] dout_n;
    logic       rdy_o8, perr_o8, ferr_o8, ovr_o8, busy_o8;
    logic [7:0] dout_o8;

    int n_cmp = 0;
    int n_err = 0;

    dpll_frame_rx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_n (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .stb_i(stb), .dat_i(dat), .lock_i(lock),
        .rd_i(rd), .rdy_o(rdy_n), .dat_o(dout_n), .perr_o(perr_n), .ferr_o(ferr_n),
        .ovr_o(ovr_n), .busy_o(busy_n)
    );

    dpll_frame_rx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_o (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .stb_i(stb), .dat_i(dat), .lock_i(lock),
        .rd_i(rd), .rdy_o(rdy_o8), .dat_o(dout_o8), .perr_o(perr_o8), .ferr_o(ferr_o8),
        .ovr_o(ovr_o8), .busy_o(busy_o8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit followed by a short randomised idle gap.
    task automatic send_bit(input logic b);
        @(negedge clk);
        dat = b;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Returns two clks after the stop strobe; early_rdy is rdy_n one clk after it.
    task automatic send_frame(input logic [7:0] d, input int par, input logic flip,
                              input logic stop, input logic rd_on_push,
                              output logic early_rdy);
        logic pbit;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par != 0) begin
            pbit = ((par == 1) ? ~(^d) : (^d)) ^ flip;
            send_bit(pbit);
        end
        @(negedge clk);
        dat = stop;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        rd  = rd_on_push;
        early_rdy = rdy_n;
        @(negedge clk);
        rd  = 1'b0;
        dat = 1'b1;
    endtask

    task automatic pop;
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic do_clr;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic er;
        rst  = 1'b1;
        clr  = 1'b0;
        stb  = 1'b0;
        dat  = 1'b1;
        lock = 1'b1;
        rd   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_rdy",  32'(rdy_n),  32'h0);
        chk("rst_dat",  32'(dout_n), 32'h0);
        chk("rst_ovr",  32'(ovr_n),  32'h0);
        chk("rst_busy", 32'(busy_n), 32'h0);
        chk("rst_flags", 32'({perr_n, ferr_n}), 32'h0);

        // 1: 8N1 0x55, push latency
        do_clr();
        send_frame(8'h55, 0, 1'b0, 1'b1, 1'b0, er);
        chk("t1_rdy_early", 32'(er), 32'h0);
        chk("t1_rdy", 32'(rdy_n), 32'h1);
        chk("t1_dat", 32'(dout_n), 32'h55);
        chk("t1_flags", 32'({perr_n, ferr_n}), 32'h0);
        chk("t1_busy", 32'(busy_n), 32'h0);

        // 2: 8O1 0xA5 with flipped parity, then a correct one
        do_clr();
        send_frame(8'hA5, 1, 1'b1, 1'b1, 1'b0, er);
        chk("t2_rdy", 32'(rdy_o8), 32'h1);
        chk("t2_dat", 32'(dout_o8), 32'hA5);
        chk("t2_perr", 32'(perr_o8), 32'h1);
        chk("t2_ferr", 32'(ferr_o8), 32'h0);
        do_clr();
        send_frame(8'h34, 1, 1'b0, 1'b1, 1'b0, er);
        chk("t2_good_dat", 32'(dout_o8), 32'h34);
        chk("t2_good_perr", 32'(perr_o8), 32'h0);

        // 3: framing error then a 12-bit low line
        do_clr();
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0, er);
        chk("t3_ferr", 32'(ferr_n), 32'h1);
        chk("t3_dat", 32'(dout_n), 32'h3C);
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        chk("t3_busy_brk", 32'(busy_n), 32'h1);
        chk("t3_head", 32'(dout_n), 32'h3C);
        pop();
        chk("t3_only_one", 32'(rdy_n), 32'h0);
        send_bit(1'b1);
        chk("t3_idle", 32'(busy_n), 32'h0);

        // 4: overrun with 5 frames into depth 4
        do_clr();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b0, 1'b1, 1'b0, er);
        chk("t4_ovr", 32'(ovr_n), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_rdy", 32'(rdy_n), 32'h1);
            chk("t4_pop", 32'(dout_n), 32'(i));
            pop();
        end
        chk("t4_empty", 32'(rdy_n), 32'h0);
        chk("t4_ovr_sticky", 32'(ovr_n), 32'h1);
        pop();
        chk("t4_underflow", 32'(rdy_n), 32'h0);
        send_frame(8'h99, 0, 1'b0, 1'b1, 1'b0, er);
        chk("t4_after_empty_rd", 32'(dout_n), 32'h99);
        pop();
        chk("t4_drained", 32'(rdy_n), 32'h0);

        // 5: pop on the same clk as the push into a full FIFO
        do_clr();
        chk("t5_clr_ovr", 32'(ovr_n), 32'h0);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1'b0, 1'b1, 1'b0, er);
        send_frame(8'h05, 0, 1'b0, 1'b1, 1'b1, er);
        chk("t5_no_ovr", 32'(ovr_n), 32'h0);
        for (int i = 2; i <= 5; i++) begin
            chk("t5_pop", 32'(dout_n), 32'(i));
            pop();
        end
        chk("t5_empty", 32'(rdy_n), 32'h0);

        // 6: lock loss mid-frame
        do_clr();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t6_busy_before", 32'(busy_n), 32'h1);
        @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        chk("t6_busy_after", 32'(busy_n), 32'h0);
        lock = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t6_no_push", 32'(rdy_n), 32'h0);
        send_frame(8'h7E, 0, 1'b0, 1'b1, 1'b0, er);
        chk("t6_rdy", 32'(rdy_n), 32'h1);
        chk("t6_dat", 32'(dout_n), 32'h7E);
        chk("t6_flags", 32'({perr_n, ferr_n}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
